// File: rtl/uart_tx_fifo_rd_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_rd_if
// Read-side handshake between a synchronous byte FIFO and its single consumer.
//
// Signals:
//   fifo_ren    read strobe, driven by the consumer (one cycle per byte)
//   fifo_empty  FIFO empty flag, driven by the FIFO
//   fifo_rdata  registered read data, valid the cycle after ren is sampled
//
// Modports:
//   master  consumer side (UART transmitter)
//   slave   FIFO side
// -----------------------------------------------------------------------------
interface uart_tx_fifo_rd_if #(
  parameter int DSIZE = 8
);
  logic             fifo_ren;
  logic             fifo_empty;
  logic [DSIZE-1:0] fifo_rdata;

  modport master (
    output fifo_ren,
    input  fifo_empty,
    input  fifo_rdata
  );

  modport slave (
    input  fifo_ren,
    output fifo_empty,
    output fifo_rdata
  );
endinterface

// File: rtl/uart_tx_fifo_rd.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_rd
// UART transmitter that drains a byte FIFO from its read side and serialises
// each byte as an 8N1 frame (LSB first). It is the only consumer of the FIFO.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit(s).
//
// Ports:
//   clk      system clock, rising edge
//   resetn   asynchronous active-low reset
//   tx_en    level enable; a new frame only starts while high
//   fifo     FIFO read port (master modport: fifo_ren out, fifo_empty /
//            fifo_rdata in)
//   tx       serial line, registered, idles high
//   busy     high whenever the FSM is not idle
//   tx_done  one-cycle pulse after the final stop-bit cycle of a frame
//
// State table:
//   state  | meaning
//   IDLE   | line idle (mark), waiting for tx_en && !fifo_empty
//   REQ    | fifo_ren high for exactly this cycle
//   WAIT   | FIFO data valid; capture into shift register, drive start bit
//   START  | start bit (space) for CLKS_PER_BIT cycles
//   DATA   | DSIZE data bits, LSB first, CLKS_PER_BIT cycles each
//   PARITY | even parity bit (only with UART_TX_PARITY_EN)
//   STOP   | STOP_BITS stop bits (mark); last edge pulses tx_done
// -----------------------------------------------------------------------------
module uart_tx_fifo_rd #(
  parameter int DSIZE        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     tx_en,
  uart_tx_fifo_rd_if.master        fifo,
  output logic                     tx,
  output logic                     busy,
  output logic                     tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DSIZE > 2) ? $clog2(DSIZE) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DSIZE - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd6;
`endif

  logic [2:0]       r_state;
  logic [CW-1:0]    r_baud;
  logic [BW-1:0]    r_bit;
  logic [DSIZE-1:0] r_shift;
  logic             r_tx;
  logic             r_ren;
  logic             r_busy;
  logic             r_done;
`ifdef UART_TX_PARITY_EN
  logic             r_par;
`endif

  logic             w_baud_last;
  logic             w_pop;
  logic [DSIZE-1:0] w_shift_nxt;

  assign w_baud_last = (r_baud == BAUD_LAST);
  // fifo_empty is only looked at where w_pop is used: IDLE and final STOP edge
  assign w_pop       = tx_en && !fifo.fifo_empty;
  assign w_shift_nxt = r_shift >> 1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ren   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_ren  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          r_bit  <= '0;
          if (w_pop) begin
            r_state <= S_REQ;
            r_ren   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_REQ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // FIFO read data is valid now, one cycle after it sampled ren
          r_shift <= fifo.fifo_rdata;
`ifdef UART_TX_PARITY_EN
          r_par   <= ^fifo.fifo_rdata;
`endif
          r_tx    <= 1'b0;
          r_baud  <= '0;
          r_bit   <= '0;
          r_state <= S_START;
        end
        S_START: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_shift <= w_shift_nxt;
            if (r_bit == BIT_LAST) begin
              r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_par;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit <= r_bit + 1'b1;
              r_tx  <= w_shift_nxt[0];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_baud_last) begin
            r_baud <= '0;
            // r_bit counts stop bits here
            if (r_bit == STOP_LAST) begin
              r_bit  <= '0;
              r_done <= 1'b1;
              if (w_pop) begin
                r_state <= S_REQ;
                r_ren   <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo.fifo_ren = r_ren;
  assign tx            = r_tx;
  assign busy          = r_busy;
  assign tx_done       = r_done;

endmodule

// File: tb/tb_uart_tx_fifo_rd.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_rd
// Bench for uart_tx_fifo_rd with CLKS_PER_BIT=4, STOP_BITS=1, DSIZE=8.
// A queue-based FIFO model answers fifo_ren; every cycle's outputs are logged
// at the falling clock edge and compared against an abstract frame model
// (slot k/CPB of a frame: start, data LSB first, optional parity, stop).
// Honours UART_TX_PARITY_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_rd;

  localparam int DSIZE = 8;
  localparam int CPB   = 4;
  localparam int SB    = 1;
`ifdef UART_TX_PARITY_EN
  localparam int FL = (2 + DSIZE + SB) * CPB;
`else
  localparam int FL = (1 + DSIZE + SB) * CPB;
`endif

  logic clk;
  logic resetn;
  logic tx_en;
  logic tx;
  logic busy;
  logic tx_done;

  uart_tx_fifo_rd_if #(.DSIZE(DSIZE)) fifo_if ();

  uart_tx_fifo_rd #(
    .DSIZE        (DSIZE),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (SB)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .tx_en   (tx_en),
    .fifo    (fifo_if),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] fq[$];
  logic [7:0] pending_data;
  bit         have_pending = 0;
  int         underflows = 0;

  logic tx_log[$];
  logic ren_log[$];
  logic done_log[$];
  logic busy_log[$];

  // one clock cycle: log outputs mid-cycle, then play the FIFO's part
  task automatic cyc();
    @(negedge clk);
    tx_log.push_back(tx);
    ren_log.push_back(fifo_if.fifo_ren);
    done_log.push_back(tx_done);
    busy_log.push_back(busy);
    if (have_pending) begin
      fifo_if.fifo_rdata = pending_data;
      have_pending = 0;
    end
    if (fifo_if.fifo_ren === 1'b1) begin
      if (fq.size() == 0) begin
        underflows++;
      end else begin
        pending_data = fq.pop_front();
        have_pending = 1;
        fifo_if.fifo_rdata = ~pending_data;
      end
      fifo_if.fifo_empty = (fq.size() == 0);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    fifo_if.fifo_empty = 1'b0;
  endtask

  task automatic flush_fifo();
    fq.delete();
    have_pending = 0;
    fifo_if.fifo_empty = 1'b1;
  endtask

  task automatic clear_logs();
    tx_log.delete();
    ren_log.delete();
    done_log.delete();
    busy_log.delete();
  endtask

  task automatic run_frames(input int n, input int budget, output bit timed_out);
    int d;
    d = 0;
    timed_out = 1;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (done_log[$] === 1'b1) d++;
      if (d >= n && busy_log[$] === 1'b0) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  // expected line level k cycles after the start bit begins
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= DSIZE) return b[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == DSIZE + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  // which: 0 = ren high, 1 = tx_done high, 2 = tx low
  function automatic int find_idx(input int which, input int from);
    for (int i = (from < 0 ? 0 : from); i < tx_log.size(); i++) begin
      if (which == 0 && ren_log[i] === 1'b1) return i;
      if (which == 1 && done_log[i] === 1'b1) return i;
      if (which == 2 && tx_log[i] === 1'b0) return i;
    end
    return -1;
  endfunction

  function automatic int count_of(input int which);
    int n;
    n = 0;
    for (int i = 0; i < tx_log.size(); i++) begin
      if (which == 0 && ren_log[i] === 1'b1) n++;
      if (which == 1 && done_log[i] === 1'b1) n++;
    end
    return n;
  endfunction

  function automatic int wave_errs(input int f, input logic [7:0] b);
    int e;
    e = 0;
    for (int k = 0; k < FL; k++) begin
      if (f < 0 || f + k >= tx_log.size()) e++;
      else if (tx_log[f+k] !== exp_bit(b, k)) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    int bad_tx, bad_ren, bad_busy, bad_done;
    logic [7:0] b;
    b = 8'($urandom());
    clear_logs();
    resetn = 1'b0;
    tx_en  = 1'b1;
    push_byte(b);
    repeat (10) cyc();
    bad_tx = 0; bad_ren = 0; bad_busy = 0; bad_done = 0;
    for (int i = 0; i < tx_log.size(); i++) begin
      if (tx_log[i] !== 1'b1) bad_tx++;
      if (ren_log[i] !== 1'b0) bad_ren++;
      if (busy_log[i] !== 1'b0) bad_busy++;
      if (done_log[i] !== 1'b0) bad_done++;
    end
    tests++;
    if (bad_tx != 0) begin fails++; $display("FAIL reset_tx: %0d cycles not high, required 0", bad_tx); end
    tests++;
    if (bad_ren != 0) begin fails++; $display("FAIL reset_ren: %0d cycles with ren, required 0", bad_ren); end
    tests++;
    if (bad_busy != 0 || bad_done != 0) begin
      fails++; $display("FAIL reset_busy_done: busy %0d done %0d cycles, required 0 0", bad_busy, bad_done);
    end
    tests++;
    if (fq.size() != 1) begin fails++; $display("FAIL reset_no_pop: fifo level %0d, required 1", fq.size()); end
    flush_fifo();
    tx_en = 1'b0;
    resetn = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic test_single(input logic [7:0] b);
    bit to;
    int r, f, d, bb;
    clear_logs();
    push_byte(b);
    tx_en = 1'b1;
    run_frames(1, FL + 40, to);
    tests++;
    if (to) begin fails++; $display("FAIL single_timeout: byte %02h frame did not finish", b); end
    r = find_idx(0, 0);
    f = find_idx(2, 0);
    d = find_idx(1, 0);
    tests++;
    if (count_of(0) != 1) begin fails++; $display("FAIL single_ren_count: got %0d required 1", count_of(0)); end
    tests++;
    if (f - r != 2) begin fails++; $display("FAIL single_ren_to_start: got %0d required 2", f - r); end
    tests++;
    if (wave_errs(f, b) != 0) begin
      fails++; $display("FAIL single_wave: byte %02h has %0d wrong cycles, required 0", b, wave_errs(f, b));
    end
    tests++;
    if (d - f != FL || count_of(1) != 1) begin
      fails++; $display("FAIL single_done: offset %0d count %0d, required %0d 1", d - f, count_of(1), FL);
    end
    bb = 0;
    for (int i = (r < 0 ? 0 : r); i < d; i++) if (busy_log[i] !== 1'b1) bb++;
    tests++;
    if (bb != 0 || d < 0 || busy_log[d] !== 1'b0) begin
      fails++; $display("FAIL single_busy: %0d idle cycles in frame, required 0", bb);
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1);
    bit to;
    int r1, r2, f1, f2;
    clear_logs();
    push_byte(b0);
    push_byte(b1);
    tx_en = 1'b1;
    run_frames(2, 2 * FL + 60, to);
    tests++;
    if (to) begin fails++; $display("FAIL b2b_timeout: frames did not finish"); end
    r1 = find_idx(0, 0);
    r2 = find_idx(0, r1 + 1);
    f1 = find_idx(2, 0);
    f2 = find_idx(2, f1 + FL);
    tests++;
    if (count_of(0) != 2 || r2 - r1 != FL + 2) begin
      fails++; $display("FAIL b2b_ren: count %0d spacing %0d, required 2 %0d", count_of(0), r2 - r1, FL + 2);
    end
    tests++;
    if (f2 - (f1 + FL) != 2) begin fails++; $display("FAIL b2b_gap: got %0d mark cycles required 2", f2 - (f1 + FL)); end
    tests++;
    if (wave_errs(f1, b0) != 0 || wave_errs(f2, b1) != 0) begin
      fails++; $display("FAIL b2b_wave: bytes %02h %02h wrong cycles %0d %0d, required 0 0",
                        b0, b1, wave_errs(f1, b0), wave_errs(f2, b1));
    end
    tests++;
    if (count_of(1) != 2) begin fails++; $display("FAIL b2b_done: got %0d pulses required 2", count_of(1)); end
  endtask

  task automatic test_empty_idle();
    int bad;
    clear_logs();
    flush_fifo();
    tx_en = 1'b1;
    repeat (100) cyc();
    bad = 0;
    for (int i = 0; i < tx_log.size(); i++) begin
      if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0) bad++;
    end
    tests++;
    if (count_of(0) != 0) begin fails++; $display("FAIL empty_ren: got %0d pulses required 0", count_of(0)); end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL empty_idle: %0d non-idle cycles required 0", bad); end
    tests++;
    if (underflows != 0) begin fails++; $display("FAIL underflow: got %0d required 0", underflows); end
    tx_en = 1'b0;
  endtask

  task automatic test_tx_en_drop();
    bit to;
    int f, n;
    logic [7:0] b0, b1;
    b0 = 8'($urandom());
    b1 = 8'($urandom());
    clear_logs();
    push_byte(b0);
    push_byte(b1);
    tx_en = 1'b1;
    f = -1;
    for (n = 0; n < 20 && f < 0; n++) begin
      cyc();
      f = find_idx(2, 0);
    end
    // land inside data bit 3 (slot 4 of the frame)
    for (n = 0; n < FL && f >= 0 && tx_log.size() < f + 4 * CPB + 2; n++) cyc();
    tx_en = 1'b0;
    run_frames(1, FL + 20, to);
    repeat (20) cyc();
    tests++;
    if (to) begin fails++; $display("FAIL drop_timeout: frame did not finish"); end
    tests++;
    if (count_of(0) != 1 || count_of(1) != 1) begin
      fails++; $display("FAIL drop_counts: ren %0d done %0d, required 1 1", count_of(0), count_of(1));
    end
    tests++;
    if (wave_errs(f, b0) != 0) begin fails++; $display("FAIL drop_wave: %0d wrong cycles required 0", wave_errs(f, b0)); end
    tests++;
    if (fq.size() != 1 || busy_log[$] !== 1'b0) begin
      fails++; $display("FAIL drop_idle: fifo level %0d busy %0d, required 1 0", fq.size(), busy_log[$]);
    end
    flush_fifo();
  endtask

  task automatic test_reset_mid();
    bit to;
    int f, r, n;
    logic [7:0] b;
    b = 8'($urandom()) & 8'hDF;
    clear_logs();
    push_byte(b);
    tx_en = 1'b1;
    f = -1;
    for (n = 0; n < 20 && f < 0; n++) begin
      cyc();
      f = find_idx(2, 0);
    end
    // last logged cycle is inside data bit 5, which is 0
    for (n = 0; n < FL && f >= 0 && tx_log.size() < f + 6 * CPB + 2; n++) cyc();
    tests++;
    if (tx_log[$] !== 1'b0) begin fails++; $display("FAIL mid_pre_reset_tx: got %0d required 0", tx_log[$]); end
    resetn = 1'b0;
    #1;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_if.fifo_ren !== 1'b0) begin
      fails++; $display("FAIL mid_reset_async: tx %0d busy %0d ren %0d, required 1 0 0", tx, busy, fifo_if.fifo_ren);
    end
    flush_fifo();
    repeat (3) cyc();
    push_byte(8'h3C);
    clear_logs();
    resetn = 1'b1;
    run_frames(1, FL + 40, to);
    r = find_idx(0, 0);
    f = find_idx(2, 0);
    tests++;
    if (to || count_of(0) != 1 || f - r != 2) begin
      fails++; $display("FAIL mid_restart: timeout %0d ren %0d latency %0d, required 0 1 2", to, count_of(0), f - r);
    end
    tests++;
    if (wave_errs(f, 8'h3C) != 0 || fq.size() != 0) begin
      fails++; $display("FAIL mid_wave: %0d wrong cycles level %0d, required 0 0", wave_errs(f, 8'h3C), fq.size());
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit to;
    int f, d;
    clear_logs();
    push_byte(8'hA5);
    tx_en = 1'b1;
    run_frames(1, FL + 40, to);
    f = find_idx(2, 0);
    d = find_idx(1, 0);
    tests++;
    if (to || f < 0 || tx_log[f + (DSIZE + 1) * CPB + 1] !== 1'b0 || d - f != 44) begin
      fails++; $display("FAIL parity_a5: timeout %0d frame length %0d, required 0 44 with parity 0", to, d - f);
    end
    clear_logs();
    push_byte(8'hA4);
    run_frames(1, FL + 40, to);
    f = find_idx(2, 0);
    tests++;
    if (to || f < 0 || tx_log[f + (DSIZE + 1) * CPB + 1] !== 1'b1) begin
      fails++; $display("FAIL parity_a4: timeout %0d, required parity bit 1", to);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x, y;
    clk = 1'b0;
    resetn = 1'b0;
    tx_en = 1'b0;
    fifo_if.fifo_empty = 1'b1;
    fifo_if.fifo_rdata = 8'h00;
    test_reset();
    test_single(8'hA5);
    repeat (4) begin
      x = 8'($urandom());
      test_single(x);
    end
    test_back_to_back(8'h00, 8'hFF);
    x = 8'($urandom());
    y = 8'($urandom());
    test_back_to_back(x, y);
    test_empty_idle();
    test_tx_en_drop();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
